// File: rtl/uart_pkg.sv
// Shared UART definitions: per-channel edge-mode encodings, parameter limits, edge-select helper.
// Latency: none (constants and a pure combinational function only).
// Backpressure: not applicable; nothing here holds state or handshakes.
package uart_pkg;

  // Per-channel edge mode, two bits per channel on the mode bus.
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Legal parameter ranges for the multi-channel pulse generator.
  localparam int PULSE_W_MIN = 1;
  localparam int PULSE_W_MAX = 255;
  localparam int CH_MIN      = 1;
  localparam int CH_MAX      = 32;

  // Select which of the rise/fall terms count as a detection for a given mode.
  function automatic logic edge_hit(input logic rise, input logic fall, input logic [1:0] mode);
    logic hit;
    case (mode)
      MODE_OFF:  hit = 1'b0;
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/uart_pulse_chan.sv
// One edge-to-pulse channel: optional 2-flop sync, edge detect, PULSE_W stretch, sticky event flag.
// Latency: pulse/event rise one edge after the sampled level changes (+2 edges with UART_MULTI_PULSE_SYNC_EN).
// Backpressure: none; free-running every cycle, retriggers extend the pulse without a gap.
module uart_pulse_chan
  import uart_pkg::*;
#(
  parameter int PULSE_W = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       lvl_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       pulse_o,
  output logic       event_o
);

  // Wide enough to hold PULSE_W itself.
  localparam int CNT_W = $clog2(PULSE_W + 1);

  if (PULSE_W < PULSE_W_MIN || PULSE_W > PULSE_W_MAX) begin : g_bad_pulse_w
    $error("uart_pulse_chan: PULSE_W out of range");
  end

  logic             s;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             event_q, event_d;
  logic             rise, fall, det;

`ifdef UART_MULTI_PULSE_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for a level that may come from another clock domain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= lvl_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  // Level is already synchronous to clk_i; use it directly.
  assign s = lvl_i;
`endif

  // Edge detect against the previous sample and compute next counter, pulse and flag values.
  always_comb begin
    rise    = s & ~prev_q;
    fall    = ~s & prev_q;
    det     = edge_hit(rise, fall, mode_i);
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    event_d = event_q;

    // A fresh detection reloads the stretch counter, otherwise it runs down to zero.
    if (det) begin
      cnt_d = CNT_W'(PULSE_W);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // cnt==1 is the last high cycle, so the flop drops once the count would reach it.
    pulse_d = det | (cnt_q > CNT_W'(1));

    // Set has priority over clear so a coincident event is never lost.
    if (det) begin
      event_d = 1'b1;
    end else if (clr_i) begin
      event_d = 1'b0;
    end
  end

  // Channel state; prev tracks the sampled level every cycle regardless of mode.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      prev_q  <= s;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      event_q <= event_d;
    end
  end

  assign pulse_o = pulse_q;
  assign event_o = event_q;

endmodule

// File: rtl/uart_multi_pulse_gen.sv
// CH-channel edge-to-pulse converter with stretched pulses, sticky event flags and an any-event OR.
// Latency: 1 edge from level change to pulse/event (3 with UART_MULTI_PULSE_SYNC_EN); any adds none.
// Backpressure: none; channels are independent and never stall, no arbitration between them.
module uart_multi_pulse_gen
  import uart_pkg::*;
#(
  parameter int CH      = 4,
  parameter int PULSE_W = 1
) (
  input  logic            i_multi_pulse_clk,
  input  logic            i_multi_pulse_rst_n,
  input  logic [CH-1:0]   i_multi_pulse_lvl_sig,
  input  logic [2*CH-1:0] i_multi_pulse_mode,
  input  logic [CH-1:0]   i_multi_pulse_clr,
  output logic [CH-1:0]   o_multi_pulse_pulse_sig,
  output logic [CH-1:0]   o_multi_pulse_event,
  output logic            o_multi_pulse_any
);

  if (CH < CH_MIN || CH > CH_MAX) begin : g_bad_ch
    $error("uart_multi_pulse_gen: CH out of range");
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    uart_pulse_chan #(
      .PULSE_W (PULSE_W)
    ) u_chan (
      .clk_i   (i_multi_pulse_clk),
      .rst_ni  (i_multi_pulse_rst_n),
      .lvl_i   (i_multi_pulse_lvl_sig[c]),
      .mode_i  (i_multi_pulse_mode[2*c +: 2]),
      .clr_i   (i_multi_pulse_clr[c]),
      .pulse_o (o_multi_pulse_pulse_sig[c]),
      .event_o (o_multi_pulse_event[c])
    );
  end

  // Flags are already registered, so the summary is a plain OR with no added delay.
  assign o_multi_pulse_any = |o_multi_pulse_event;

endmodule
